// File: rtl/eth_kv_tx.sv
// Serialises KV response records into fixed 60-byte Ethernet frames (8 x 64-bit AXIS beats).
// First beat 1 cycle after a record lands in an empty queue; records queue during MAC stalls, req_ready drops when full.
module eth_kv_tx #(
    parameter logic [47:0] DST_MAC    = 48'hFFFFFFFFFFFF,
    parameter logic [47:0] SRC_MAC    = 48'h001122334455,
    parameter logic [15:0] ETH_TYPE   = 16'h88B5,
    parameter int          KEY_SIZE   = 96,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                clk156,
    input  logic                eth_rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_SIZE-1:0] req_key,
    input  logic [3:0]          req_flag,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [63:0]         m_axis_tdata,
    output logic [7:0]          m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic                m_axis_tuser,
    output logic [31:0]         tx_count,
    output logic                busy
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int KB = KEY_SIZE / 8;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    typedef struct packed {
        logic [KEY_SIZE-1:0] key;
        logic [3:0]          flag;
    } rec_t;

    typedef enum logic {IDLE, SEND} state_t;

    rec_t          q_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   q_cnt;
    logic [AW:0]   cnt_nxt;
    logic          push;
    logic          pop;
    logic          q_nonempty;

    state_t        state;
    logic [2:0]    beat;
    logic [2:0]    beat_inc;
    logic [7:0]    seq;
    rec_t          cur;
    logic [511:0]  frame_flat;

    assign push       = req_valid && req_ready;
    assign q_nonempty = (q_cnt != '0);
    assign pop        = q_nonempty &&
                        ((state == IDLE) || (m_axis_tready && (beat == 3'd7)));
    assign beat_inc   = beat + 3'd1;
    assign busy       = (state == SEND) || q_nonempty;
    assign m_axis_tuser = 1'b0;

    always_comb begin
        cnt_nxt = q_cnt;
        if (push && !pop)
            cnt_nxt = q_cnt + CNT_ONE;
        else if (!push && pop)
            cnt_nxt = q_cnt - CNT_ONE;
    end

    always_ff @(posedge clk156) begin
        if (push)
            q_mem[wr_ptr] <= '{key: req_key, flag: req_flag};
    end

    // req_ready is registered from the next occupancy, so a full queue refuses pushes even while popping.
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_cnt     <= '0;
            req_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            q_cnt     <= cnt_nxt;
            req_ready <= (cnt_nxt != FULL_CNT);
        end
    end

    // Whole frame as a flat byte vector, byte k at [8k+7:8k]; beat n is bits [64n+63:64n].
    always_comb begin
        frame_flat = '0;
        for (int k = 0; k < 6; k++) begin
            frame_flat[8*k +: 8]      = DST_MAC[47-8*k -: 8];
            frame_flat[48+8*k +: 8]   = SRC_MAC[47-8*k -: 8];
        end
        frame_flat[96 +: 8]  = ETH_TYPE[15:8];
        frame_flat[104 +: 8] = ETH_TYPE[7:0];
        frame_flat[112 +: 8] = {4'h0, cur.flag};
        frame_flat[120 +: 8] = seq;
        for (int k = 0; k < KB; k++)
            frame_flat[128+8*k +: 8] = cur.key[KEY_SIZE-1-8*k -: 8];
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state         <= IDLE;
            beat          <= 3'd0;
            seq           <= 8'd0;
            cur           <= '0;
            tx_count      <= 32'd0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 64'd0;
            m_axis_tkeep  <= 8'd0;
            m_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (q_nonempty) begin
                        cur           <= q_mem[rd_ptr];
                        beat          <= 3'd0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= frame_flat[63:0];
                        m_axis_tkeep  <= 8'hFF;
                        m_axis_tlast  <= 1'b0;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (m_axis_tready) begin
                        if (beat != 3'd7) begin
                            beat         <= beat_inc;
                            m_axis_tdata <= frame_flat[{beat_inc, 6'd0} +: 64];
                            m_axis_tkeep <= (beat_inc == 3'd7) ? 8'h0F : 8'hFF;
                            m_axis_tlast <= (beat_inc == 3'd7);
                        end else begin
                            tx_count <= tx_count + 32'd1;
                            seq      <= seq + 8'd1;
                            // Beat 0 carries no record fields, so the next frame can start without a bubble.
                            if (q_nonempty) begin
                                cur          <= q_mem[rd_ptr];
                                beat         <= 3'd0;
                                m_axis_tdata <= frame_flat[63:0];
                                m_axis_tkeep <= 8'hFF;
                                m_axis_tlast <= 1'b0;
                            end else begin
                                state         <= IDLE;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tdata  <= 64'd0;
                                m_axis_tkeep  <= 8'd0;
                                m_axis_tlast  <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_kv_tx.sv
// Scoreboard bench for eth_kv_tx: reference frames built byte-by-byte from the frame layout rules.
module tb_eth_kv_tx;

    logic         clk156 = 1'b0;
    logic         eth_rst;
    logic         req_valid;
    logic         req_ready;
    logic [95:0]  req_key;
    logic [3:0]   req_flag;
    logic         m_axis_tvalid;
    logic         m_axis_tready;
    logic [63:0]  m_axis_tdata;
    logic [7:0]   m_axis_tkeep;
    logic         m_axis_tlast;
    logic         m_axis_tuser;
    logic [31:0]  tx_count;
    logic         busy;

    always #5 clk156 = ~clk156;

    eth_kv_tx dut (
        .clk156(clk156), .eth_rst(eth_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_flag(req_flag),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .tx_count(tx_count), .busy(busy)
    );

    typedef struct packed {
        logic [63:0] dat;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    localparam logic [47:0] T_DST = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] T_SRC = 48'h001122334455;

    beat_t       exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [7:0]  model_seq = 8'd0;
    int          model_tx = 0;
    int          cyc = 0;
    int          hs_in_frame = 0;
    int          hs_cyc[$];
    logic [63:0] dat_log[$];
    logic [7:0]  keep_log[$];
    logic [7:0]  seq_seen[$];
    logic        stall_prev = 1'b0;
    logic [72:0] stall_val;
    beat_t       mon_e;
    bit          pusher_done;

    logic [63:0] t1_exp [8] = '{64'h1100FFFFFFFFFFFF, 64'h0003B58855443322,
                                64'h0807060504030201, 64'h000000000C0B0A09,
                                64'h0, 64'h0, 64'h0, 64'h0};

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: lay the 60 frame bytes out in an array, then cut into 8-byte beats.
    task automatic model_push(input logic [95:0] key, input logic [3:0] flag);
        logic [7:0] b [64];
        beat_t e;
        for (int i = 0; i < 64; i++) b[i] = 8'h00;
        for (int i = 0; i < 6; i++) begin
            b[i]   = 8'(T_DST >> (40 - 8*i));
            b[6+i] = 8'(T_SRC >> (40 - 8*i));
        end
        b[12] = 8'h88;
        b[13] = 8'hB5;
        b[14] = {4'h0, flag};
        b[15] = model_seq;
        for (int i = 0; i < 12; i++) b[16+i] = 8'(key >> (88 - 8*i));
        model_seq = model_seq + 8'd1;
        for (int bt = 0; bt < 8; bt++) begin
            e.dat = 64'd0;
            for (int i = 0; i < 8; i++) e.dat[8*i +: 8] = b[8*bt+i];
            e.keep = (bt == 7) ? 8'h0F : 8'hFF;
            e.last = (bt == 7);
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk156) begin
        cyc++;
        if (eth_rst) begin
            stall_prev  = 1'b0;
            hs_in_frame = 0;
        end else begin
            if (m_axis_tvalid && !m_axis_tready) begin
                if (stall_prev)
                    chk("stall_hold", 80'({m_axis_tdata, m_axis_tkeep, m_axis_tlast}), 80'(stall_val));
                stall_prev = 1'b1;
                stall_val  = {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
            end else begin
                stall_prev = 1'b0;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cyc.push_back(cyc);
                dat_log.push_back(m_axis_tdata);
                keep_log.push_back(m_axis_tkeep);
                if (hs_in_frame == 1) seq_seen.push_back(m_axis_tdata[63:56]);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=%h required=none", m_axis_tdata);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", 80'({m_axis_tuser, m_axis_tdata, m_axis_tkeep, m_axis_tlast}),
                        80'({1'b0, mon_e.dat, mon_e.keep, mon_e.last}));
                end
                if (m_axis_tlast) begin
                    hs_in_frame = 0;
                    model_tx++;
                end else begin
                    hs_in_frame++;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk156);
        #1;
    endtask

    task automatic clear_logs;
        hs_cyc.delete();
        dat_log.delete();
        keep_log.delete();
    endtask

    task automatic do_reset;
        eth_rst   = 1'b1;
        req_valid = 1'b0;
        exp_q.delete();
        seq_seen.delete();
        model_seq = 8'd0;
        model_tx  = 0;
        repeat (3) tick;
        eth_rst = 1'b0;
        tick;
        clear_logs;
    endtask

    task automatic push(input logic [95:0] key, input logic [3:0] flag);
        bit ok = 1'b0;
        req_key   = key;
        req_flag  = flag;
        req_valid = 1'b1;
        for (int t = 0; t < 3000 && !ok; t++) begin
            @(negedge clk156);
            ok = req_ready;
            tick;
        end
        req_valid = 1'b0;
        if (ok) begin
            model_push(key, flag);
        end else begin
            checks++;
            failures++;
            $display("FAIL push_timeout actual=no_accept required=accept");
        end
    endtask

    task automatic drain(input int budget);
        bit done = 1'b0;
        for (int t = 0; t < budget && !done; t++) begin
            tick;
            done = (exp_q.size() == 0) && !busy && !m_axis_tvalid;
        end
        chk("drain_complete", 80'(done), 80'(1));
        chk("tx_count_model", 80'(tx_count), 80'(model_tx));
    endtask

    task automatic wait_beat(input int n);
        bit hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            tick;
            hit = (hs_in_frame == n);
        end
        chk("wait_beat", 80'(hit), 80'(1));
    endtask

    logic [63:0] held;
    int          rdy_hits;

    initial begin
        eth_rst = 1'b1;
        req_valid = 1'b0;
        req_key = '0;
        req_flag = '0;
        m_axis_tready = 1'b1;
        repeat (3) tick;
        chk("rst_req_ready", 80'(req_ready), 80'(0));
        chk("rst_tvalid", 80'(m_axis_tvalid), 80'(0));
        chk("rst_tdata", 80'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 80'(0));
        chk("rst_tx_count", 80'(tx_count), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        eth_rst = 1'b0;
        tick;
        chk("post_rst_req_ready", 80'(req_ready), 80'(1));

        // single directed frame
        clear_logs;
        push(96'h0102030405060708090A0B0C, 4'h3);
        chk("latency_e", 80'(m_axis_tvalid), 80'(0));
        tick;
        chk("latency_e1", 80'(m_axis_tvalid), 80'(1));
        drain(200);
        chk("t1_beats", 80'(hs_cyc.size()), 80'(8));
        if (hs_cyc.size() == 8) begin
            chk("t1_span", 80'(hs_cyc[7] - hs_cyc[0]), 80'(7));
            for (int i = 0; i < 8; i++) chk($sformatf("t1_beat%0d", i), 80'(dat_log[i]), 80'(t1_exp[i]));
            chk("t1_keep0", 80'(keep_log[0]), 80'(8'hFF));
            chk("t1_keep7", 80'(keep_log[7]), 80'(8'h0F));
        end
        chk("t1_tx_count", 80'(tx_count), 80'(1));
        chk("t1_busy", 80'(busy), 80'(0));

        // back-to-back records
        do_reset;
        push({$urandom, $urandom, $urandom}, 4'(($urandom)));
        push({$urandom, $urandom, $urandom}, 4'(($urandom)));
        drain(200);
        chk("t2_beats", 80'(hs_cyc.size()), 80'(16));
        if (hs_cyc.size() == 16) chk("t2_span", 80'(hs_cyc[15] - hs_cyc[0]), 80'(15));
        if (seq_seen.size() == 2) chk("t2_seq1", 80'(seq_seen[1]), 80'(8'h01));

        // stall at beat 3
        clear_logs;
        push({$urandom, $urandom, $urandom}, 4'h9);
        wait_beat(3);
        m_axis_tready = 1'b0;
        held = m_axis_tdata;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("t3_hold", 80'({m_axis_tvalid, m_axis_tdata}), 80'({1'b1, held}));
        end
        m_axis_tready = 1'b1;
        drain(200);
        chk("t3_handshakes", 80'(hs_cyc.size()), 80'(8));
        if (hs_cyc.size() == 8) chk("t3_beat3", 80'(dat_log[3]), 80'(held));

        // full queue with MAC stalled
        do_reset;
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push({$urandom, $urandom, $urandom}, 4'(i));
            if (i == 3) chk("t4_ready_at4", 80'(req_ready), 80'(1));
        end
        chk("t4_ready_full", 80'(req_ready), 80'(0));
        req_key = {$urandom, $urandom, $urandom};
        req_valid = 1'b1;
        rdy_hits = 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (req_ready) rdy_hits++;
        end
        req_valid = 1'b0;
        chk("t4_sixth_refused", 80'(rdy_hits), 80'(0));
        chk("t4_no_beats", 80'(dat_log.size()), 80'(0));
        m_axis_tready = 1'b1;
        drain(300);
        chk("t4_frames", 80'(seq_seen.size()), 80'(5));
        for (int i = 0; i < seq_seen.size(); i++) chk("t4_seq", 80'(seq_seen[i]), 80'(i));
        chk("t4_tx_count", 80'(tx_count), 80'(5));

        // reset mid-frame with records queued
        do_reset;
        for (int i = 0; i < 3; i++) push({$urandom, $urandom, $urandom}, 4'(i));
        wait_beat(4);
        eth_rst = 1'b1;
        exp_q.delete();
        seq_seen.delete();
        model_seq = 8'd0;
        model_tx = 0;
        tick;
        chk("t5_tvalid", 80'(m_axis_tvalid), 80'(0));
        chk("t5_tx_count", 80'(tx_count), 80'(0));
        chk("t5_busy", 80'(busy), 80'(0));
        eth_rst = 1'b0;
        tick;
        push({$urandom, $urandom, $urandom}, 4'hC);
        drain(200);
        chk("t5_frames", 80'(seq_seen.size()), 80'(1));
        if (seq_seen.size() == 1) chk("t5_seq0", 80'(seq_seen[0]), 80'(8'h00));

        // 300 random frames with random backpressure
        do_reset;
        pusher_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    repeat ($urandom_range(0, 2)) tick;
                    push({$urandom, $urandom, $urandom}, 4'($urandom));
                end
                pusher_done = 1'b1;
            end
            begin
                while (!pusher_done) begin
                    m_axis_tready = ($urandom_range(0, 3) != 0);
                    tick;
                end
                m_axis_tready = 1'b1;
            end
        join
        drain(3000);
        chk("t6_tx_count", 80'(tx_count), 80'(300));
        chk("t6_frames", 80'(seq_seen.size()), 80'(300));
        if (seq_seen.size() == 300) begin
            chk("t6_seq255", 80'(seq_seen[255]), 80'(8'hFF));
            chk("t6_seq256", 80'(seq_seen[256]), 80'(8'h00));
            chk("t6_seq299", 80'(seq_seen[299]), 80'(8'd43));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

endmodule

// File: doc/eth_kv_tx.md
Name: eth_kv_tx

Overview:
- Transmit-side counterpart to the KV request decapsulator: accepts key/flag response records from the KV engine and serialises each into a fixed-format 60-byte Ethernet frame on a 64-bit AXI4-Stream master to the 10G MAC TX port.
- Includes a small request queue, so the engine is only backpressured when the MAC stalls for a long time.
- Runs entirely in the clk156 domain.

Parameters:
- DST_MAC, 48'hFFFFFFFFFFFF, destination MAC; byte 0 of the frame is DST_MAC[47:40].
- SRC_MAC, 48'h001122334455, source MAC; byte 6 of the frame is SRC_MAC[47:40].
- ETH_TYPE, 16'h88B5, EtherType; byte 12 is ETH_TYPE[15:8].
- KEY_SIZE, 96, key width; fixed at 96 (12 bytes).
- FIFO_DEPTH, 4, request queue entries; must be a power of 2 and at least 2.

Ports:
- clk156  in  1  core clock, 156.25 MHz.
- eth_rst  in  1  synchronous, active-high reset.
- req_valid  in  1  response record valid.
- req_ready  out  1  queue can accept a record.
- req_key  in  KEY_SIZE  key to return.
- req_flag  in  4  result flag.
- m_axis_tvalid  out  1  AXIS beat valid.
- m_axis_tready  in  1  MAC ready.
- m_axis_tdata  out  64  beat data; [7:0] is the earliest byte on the wire.
- m_axis_tkeep  out  8  byte enables.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tuser  out  1  always 0.
- tx_count  out  32  frames fully accepted by the MAC; wraps.
- busy  out  1  FSM in SEND, or queue non-empty.

Behaviour:
- Clock and reset: one clock, clk156; reset eth_rst is synchronous and active-high.
- Reset values: m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0, tuser=0, tx_count=0, busy=0, queue empty, seq=0, req_ready=0 during reset, 1 afterwards.
- Reset mid-frame: outputs drop to reset values at that edge. The queued records and the partial frame are discarded. The MAC shares eth_rst, so the truncated frame is acceptable.
- Queue: a record is pushed on every edge with req_valid&&req_ready. req_ready = !full, registered from occupancy.
  - A push is refused when full, even if a pop happens in the same cycle.
  - Simultaneous push and pop when not full leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame layout (byte index):
  - 0-5: DST_MAC.
  - 6-11: SRC_MAC.
  - 12-13: ETH_TYPE.
  - 14: {4'h0, flag}.
  - 15: seq.
  - 16-27: key, MSB first (byte 16 = key[95:88]).
  - 28-59: zero.
- Beat layout: 8 beats. Beats 0-6 have tkeep=8'hFF. Beat 7 has tkeep=8'h0F and tlast=1. No FCS; the MAC appends it.
- FSM states:
  - IDLE: tvalid=0. If the queue is non-empty, pop the head, register beat 0, beat=0, go to SEND.
  - SEND: tvalid=1; outputs are held stable while tready=0.
    - On tvalid&&tready with beat<7: beat+1, register the next beat.
    - On tvalid&&tready with beat=7: tx_count+1 and seq+1 (8-bit, wraps 255->0).
      - If the queue is non-empty: pop and present the next frame's beat 0 on the following cycle (tvalid stays 1, no bubble).
      - Else go to IDLE.
- Latency: a record accepted at edge E into an empty queue with the FSM in IDLE gives tvalid=1 from edge E+1. Minimum frame spacing is 8 cycles.
- tready may toggle arbitrarily. No beat is dropped or duplicated, and tdata/tkeep/tlast never change while tvalid&&!tready.
- seq counts transmitted frames only; it is not reset between frames.

Test Plan:
- Single record, key=96'h0102030405060708090A0B0C, flag=4'h3, tready=1, defaults → exactly 8 beats on consecutive cycles:
  - beat0 64'h1100FFFFFFFFFFFF.
  - beat1 64'h0003B58855443322.
  - beat2 64'h0807060504030201.
  - beat3 64'h000000000C0B0A09.
  - beats 4-6 zero.
  - beat7 zero, tkeep 8'h0F, tlast=1.
  - Then tx_count=1, busy=0.
- Two records pushed back-to-back, tready=1 → 16 consecutive tvalid cycles with no gap; the second frame's beat1 byte 15 = 8'h01.
- tready=0 for 5 cycles starting at beat 3, then 1 → beat 3 data held unchanged all 5 cycles; frame completes; total 8 handshakes.
- tready=0 permanently, push 6 records → req_ready deasserts after the queue holds 4 (1 in flight plus 4 queued). Release tready → 5 frames with seq 0..4; the 6th record is never accepted while req_ready=0.
- 300 frames sent → seq wraps; frame 257 carries seq 8'h00; tx_count=300.
- eth_rst asserted at beat 4 with 2 records queued → tvalid=0 on the next cycle, tx_count=0, busy=0. After release, a new record yields a frame with seq 8'h00.
